lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/npc_pkg.sv | 30 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 160 ++++++++++++++++
 tb/tb_lsu.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared encodings for the core: decoder opcodes, load/store formats and LSU FSM states.
package npc_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_RESP = 2'b11
  } lsu_state_e;

  function automatic logic mem_op_valid(input logic [2:0] op);
    logic ok;
    case (op)
      MEM_OP_B, MEM_OP_H, MEM_OP_W, MEM_OP_BU, MEM_OP_HU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store lane shift, load shift and extension.
module lsu_align
  import npc_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted_s;

  // Halves only look at offset[1] and words ignore the offset entirely.
  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = wdata;
    shifted_s  = rdata_word;
    rdata_ext  = 32'h0000_0000;
    case (mem_op)
      MEM_OP_B, MEM_OP_BU: begin
        wmask      = 4'b0001 << offset;
        wdata_lane = wdata << {offset, 3'b000};
        shifted_s  = rdata_word >> {offset, 3'b000};
      end
      MEM_OP_H, MEM_OP_HU: begin
        wmask      = 4'b0011 << {offset[1], 1'b0};
        wdata_lane = wdata << {offset[1], 4'b0000};
        shifted_s  = rdata_word >> {offset[1], 4'b0000};
      end
      MEM_OP_W: begin
        wmask = 4'b1111;
      end
      default: begin
        wmask = 4'b0000;
      end
    endcase
    case (mem_op)
      MEM_OP_B:  rdata_ext = {{24{shifted_s[7]}}, shifted_s[7:0]};
      MEM_OP_BU: rdata_ext = {24'h00_0000, shifted_s[7:0]};
      MEM_OP_H:  rdata_ext = {{16{shifted_s[15]}}, shifted_s[15:0]};
      MEM_OP_HU: rdata_ext = {16'h0000, shifted_s[15:0]};
      MEM_OP_W:  rdata_ext = shifted_s;
      default:   rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/REQ/WAIT/RESP handshake between core and a single-word bus.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of ignoring low address bits.
module lsu
  import npc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic [3:0]  bus_wmask,
  output logic [31:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  lsu_state_e  state_r, state_next_s;
  logic        store_r;
  logic [2:0]  op_r;
  logic [1:0]  offset_r;
  logic        resp_valid_r, misalign_r, bus_req_valid_r, bus_wen_r;
  logic [31:0] rdata_r, bus_addr_r, bus_wdata_r;
  logic [3:0]  bus_wmask_r;
  logic        accept_s, access_s, fault_s, bypass_s;
  logic [2:0]  align_op_s;
  logic [1:0]  align_offset_s;
  logic [3:0]  wmask_s;
  logic [31:0] wdata_lane_s, rdata_ext_s;

  assign req_ready = (state_r == LSU_IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;
  assign access_s  = mem_rd || mem_wr;
`ifdef LSU_MISALIGN_CHECK_EN
  assign fault_s = access_s &&
                   ((((mem_op == MEM_OP_H) || (mem_op == MEM_OP_HU)) && addr[0]) ||
                    ((mem_op == MEM_OP_W) && (addr[1:0] != 2'b00)));
`else
  assign fault_s = 1'b0;
`endif
  assign bypass_s = !access_s || !mem_op_valid(mem_op) || fault_s;

  assign resp_valid    = resp_valid_r;
  assign rdata         = rdata_r;
  assign misalign      = misalign_r;
  assign bus_req_valid = bus_req_valid_r;
  assign bus_addr      = bus_addr_r;
  assign bus_wen       = bus_wen_r;
  assign bus_wmask     = bus_wmask_r;
  assign bus_wdata     = bus_wdata_r;

  // Align unit sees the incoming request in IDLE and the latched access afterwards.
  always_comb begin
    align_op_s     = op_r;
    align_offset_s = offset_r;
    if (state_r == LSU_IDLE) begin
      align_op_s     = mem_op;
      align_offset_s = addr[1:0];
    end else begin
      align_op_s     = op_r;
      align_offset_s = offset_r;
    end
  end

  lsu_align u_align (
    .mem_op     (align_op_s),
    .offset     (align_offset_s),
    .wdata      (wdata),
    .rdata_word (bus_rdata),
    .wmask      (wmask_s),
    .wdata_lane (wdata_lane_s),
    .rdata_ext  (rdata_ext_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= LSU_IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic; bus_resp_valid only matters in WAIT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if (accept_s) state_next_s = bypass_s ? LSU_RESP : LSU_REQ;
        else          state_next_s = LSU_IDLE;
      end
      LSU_REQ: begin
        if (bus_req_ready) state_next_s = LSU_WAIT;
        else               state_next_s = LSU_REQ;
      end
      LSU_WAIT: begin
        if (bus_resp_valid) state_next_s = LSU_RESP;
        else                state_next_s = LSU_WAIT;
      end
      LSU_RESP: state_next_s = LSU_IDLE;
      default:  state_next_s = LSU_IDLE;
    endcase
  end

  // Request latches and registered outputs; bus fields hold steady while REQ waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_r         <= 1'b0;
      op_r            <= 3'b000;
      offset_r        <= 2'b00;
      resp_valid_r    <= 1'b0;
      misalign_r      <= 1'b0;
      rdata_r         <= 32'h0000_0000;
      bus_req_valid_r <= 1'b0;
      bus_addr_r      <= 32'h0000_0000;
      bus_wen_r       <= 1'b0;
      bus_wmask_r     <= 4'b0000;
      bus_wdata_r     <= 32'h0000_0000;
    end else begin
      resp_valid_r <= (state_next_s == LSU_RESP);
      case (state_r)
        LSU_IDLE: begin
          if (accept_s) begin
            store_r  <= mem_wr;
            op_r     <= mem_op;
            offset_r <= addr[1:0];
            if (bypass_s) begin
              rdata_r    <= 32'h0000_0000;
              misalign_r <= fault_s;
            end else begin
              misalign_r      <= 1'b0;
              bus_req_valid_r <= 1'b1;
              bus_addr_r      <= {addr[31:2], 2'b00};
              bus_wen_r       <= mem_wr;
              bus_wmask_r     <= wmask_s;
              bus_wdata_r     <= wdata_lane_s;
            end
          end
        end
        LSU_REQ: begin
          if (bus_req_ready) bus_req_valid_r <= 1'b0;
        end
        LSU_WAIT: begin
          if (bus_resp_valid && !store_r) rdata_r <= rdata_ext_s;
        end
        default: begin
          bus_req_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed scenarios plus randomized accesses against an arithmetic model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, mem_rd, mem_wr;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata, rdata;
  logic        resp_valid, misalign;
  logic        bus_req_valid, bus_req_ready, bus_wen, bus_resp_valid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wmask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          misalign;
    int          resp_cyc;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    bit          wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] care;
    logic [31:0] word;
    int          rwait;
    int          rdelay;
  } bus_t;

  sb_t  sb_q[$];
  bus_t bus_q[$];

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_op(mem_op), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .misalign(misalign),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_wen(bus_wen), .bus_wmask(bus_wmask), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] op, input int lo, input logic [31:0] word);
    logic [31:0] lane;
    lane = word >> (8 * lo);
    case (op)
      3'b000: begin lane = lane & 32'hFF;   if (lane >= 32'd128)   lane = lane + 32'hFFFF_FF00; end
      3'b100: lane = lane & 32'hFF;
      3'b001: begin lane = lane & 32'hFFFF; if (lane >= 32'd32768) lane = lane + 32'hFFFF_0000; end
      3'b101: lane = lane & 32'hFFFF;
      3'b010: lane = word;
      default: lane = 32'h0;
    endcase
    return lane;
  endfunction

  // Bus slave: ready after rwait cycles of request, response pulse rdelay cycles after handshake.
  bus_t        cur;
  bit          prev_valid = 1'b0, hs_pending = 1'b0;
  int          resp_cnt = -1, wait_cnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_mask;
  logic        cap_wen;

  initial begin
    bus_req_ready  = 1'b1;
    bus_resp_valid = 1'b0;
    bus_rdata      = 32'h0;
  end

  always @(posedge clk) begin
    #1;
    bus_resp_valid = 1'b0;
    if (hs_pending) resp_cnt = cur.rdelay;
    if (resp_cnt == 0) begin
      bus_resp_valid = 1'b1;
      bus_rdata      = cur.word;
      resp_cnt       = -1;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
    end
    if (bus_req_valid === 1'b1 && !prev_valid) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bus_req actual=1 expected=0 addr=%h", bus_addr);
        cur.rwait = 0; cur.rdelay = 0; cur.word = 32'h0;
      end else begin
        cur = bus_q.pop_front();
        check("bus_addr", bus_addr, cur.addr);
        check("bus_wen", {31'h0, bus_wen}, {31'h0, cur.wen});
        check("bus_wmask", {28'h0, bus_wmask}, {28'h0, cur.mask});
        if (cur.wen) check("bus_wdata", bus_wdata & cur.care, cur.wdata & cur.care);
      end
      cap_addr = bus_addr; cap_wdata = bus_wdata; cap_mask = bus_wmask; cap_wen = bus_wen;
      wait_cnt = 0;
    end else if (bus_req_valid === 1'b1) begin
      check("stable_addr", bus_addr, cap_addr);
      check("stable_wdata", bus_wdata, cap_wdata);
      check("stable_wmask", {28'h0, bus_wmask}, {28'h0, cap_mask});
      check("stable_wen", {31'h0, bus_wen}, {31'h0, cap_wen});
    end
    if (bus_req_valid === 1'b1) begin
      bus_req_ready = (wait_cnt >= cur.rwait);
      if (!bus_req_ready) wait_cnt++;
    end else begin
      bus_req_ready = 1'b1;
    end
    prev_valid = (bus_req_valid === 1'b1);
    hs_pending = (bus_req_valid === 1'b1) && bus_req_ready;
  end

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_t e;
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp actual=1 expected=0 cycle=%0d", cyc);
      end else begin
        e = sb_q.pop_front();
        if (e.chk_rdata) check("rdata", rdata, e.rdata);
        check("misalign", {31'h0, misalign}, {31'h0, e.misalign});
        check("resp_cycle", cyc, e.resp_cyc);
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int rwait, input int rdelay);
    bit   access, defined, is_half, is_word, mis, fault, bypass;
    int   lo, n;
    sb_t  s;
    bus_t b;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin tick(); n++; end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout actual=%b expected=1", req_ready);
      return;
    end
    access  = rd || wr;
    defined = op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    is_half = op inside {3'b001, 3'b101};
    is_word = (op == 3'b010);
    mis     = (is_half && a[0]) || (is_word && a[1:0] != 2'b00);
`ifdef LSU_MISALIGN_CHECK_EN
    fault = access && defined && mis;
`else
    fault = 1'b0;
`endif
    bypass = !access || !defined || fault;
    lo = is_word ? 0 : (is_half ? 2 * int'(a[1]) : int'(a[1:0]));
    if (bypass) begin
      s.rdata = 32'h0; s.chk_rdata = 1'b1; s.misalign = fault; s.resp_cyc = cyc + 1;
    end else begin
      b.addr   = {a[31:2], 2'b00};
      b.wen    = wr;
      b.mask   = (is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001)) << lo;
      b.wdata  = wd << (8 * lo);
      for (int i = 0; i < 4; i++) b.care[8*i +: 8] = {8{b.mask[i]}};
      b.word   = word;
      b.rwait  = rwait;
      b.rdelay = rdelay;
      bus_q.push_back(b);
      s.rdata = model_load(op, lo, word); s.chk_rdata = !wr; s.misalign = 1'b0;
      s.resp_cyc = cyc + 1 + 2 + rwait + rdelay;
    end
    sb_q.push_back(s);
    req_valid = 1'b1; mem_rd = rd; mem_wr = wr; mem_op = op; addr = a; wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus_q.size() != 0 || req_ready !== 1'b1) && n < 200) begin tick(); n++; end
    if (sb_q.size() != 0 || bus_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", sb_q.size() + bus_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_op = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (3) tick();
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_bus_req_valid", {31'h0, bus_req_valid}, 32'h0);
    check("rst_bus_wen", {31'h0, bus_wen}, 32'h0);
    check("rst_bus_wmask", {28'h0, bus_wmask}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);

    issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 0, 0);
    wait_done();
    issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h1111_2222, 0, 3);
    wait_done();

    issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 5, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
      check("bp_bus_req_valid", {31'h0, bus_req_valid}, 32'h1);
      tick();
    end
    wait_done();

    issue(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0);
    wait_done();

    issue(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h1234_5678, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_no_bus_req", {31'h0, bus_req_valid}, 32'h0);
`endif
    wait_done();

    issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'hDEAD_BEEF, 0, 6);
    tick();
    rst = 1'b1;
    sb_q.delete();
    tick();
    check("rstw_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rstw_req_ready", {31'h0, req_ready}, 32'h0);
    check("rstw_bus_req_valid", {31'h0, bus_req_valid}, 32'h0);
    rst = 1'b0;
    tick();
    check("rstw_req_ready_after", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("rstw_idle_ready", {31'h0, req_ready}, 32'h1);
      check("rstw_idle_bus", {31'h0, bus_req_valid}, 32'h0);
      tick();
    end

    for (int i = 0; i < 200; i++) begin
      bit rd, wr;
      int k;
      k  = $urandom_range(0, 9);
      rd = (k < 5) || (k == 9);
      wr = (k >= 5);
      if (k == 8) begin rd = 1'b0; wr = 1'b0; end
      issue(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
    end
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
